// File: rtl/cv32e40px_rf_wb_arbiter.sv
// Write-back arbiter for regfile ports A and B.
// Port A takes EX results. Port B takes the LSU load when one is valid; otherwise it
// takes the head of a small XIF result FIFO. Both ports are registered.
// Optional destination scoreboard: define CV32E40PX_RF_WB_SCOREBOARD_EN.
module cv32e40px_rf_wb_arbiter #(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int XIF_FIFO_DEPTH = 4,
  parameter int NUM_REGS       = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ex_valid_i,
  output logic                                ex_ready_o,
  input  logic [ADDR_WIDTH-1:0]               ex_waddr_i,
  input  logic [DATA_WIDTH-1:0]               ex_wdata_i,
  input  logic                                lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0]               lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]               lsu_wdata_i,
  input  logic                                xif_valid_i,
  output logic                                xif_ready_o,
  input  logic [ADDR_WIDTH-1:0]               xif_waddr_i,
  input  logic [DATA_WIDTH-1:0]               xif_wdata_i,
  input  logic                                rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]               rsv_addr_i,
  output logic [NUM_REGS-1:0]                 busy_o,
  output logic [$clog2(XIF_FIFO_DEPTH):0]     fifo_level_o,
  output logic                                we_a_o,
  output logic [ADDR_WIDTH-1:0]               waddr_a_o,
  output logic [DATA_WIDTH-1:0]               wdata_a_o,
  output logic                                we_b_o,
  output logic [ADDR_WIDTH-1:0]               waddr_b_o,
  output logic [DATA_WIDTH-1:0]               wdata_b_o
);

  localparam int PW = $clog2(XIF_FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic [ADDR_WIDTH-1:0] r_fifo_addr [XIF_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [XIF_FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [LW-1:0]         r_count;

  logic                  r_we_a, r_we_b;
  logic [ADDR_WIDTH-1:0] r_waddr_a, r_waddr_b;
  logic [DATA_WIDTH-1:0] r_wdata_a, r_wdata_b;

  logic                  w_full, w_empty, w_push, w_pop;
  logic                  w_b_valid, w_ex_acc, w_a_we, w_b_we;
  logic [ADDR_WIDTH-1:0] w_b_addr;
  logic [DATA_WIDTH-1:0] w_b_data;

  // Ready comes from the registered count only, so a full FIFO refuses a push
  // even in a cycle where it is also draining.
  assign w_full      = (r_count == LW'(XIF_FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign xif_ready_o = !w_full;
  assign w_push      = xif_valid_i && !w_full;

  // An LSU load has priority on port B. The FIFO head stays in place until B is free.
  assign w_pop     = !lsu_valid_i && !w_empty;
  assign w_b_valid = lsu_valid_i || w_pop;
  assign w_b_addr  = lsu_valid_i ? lsu_waddr_i : r_fifo_addr[r_rptr];
  assign w_b_data  = lsu_valid_i ? lsu_wdata_i : r_fifo_data[r_rptr];

  // If EX targets the register that port B writes this cycle, EX stalls for one cycle.
  // The stall keeps the two writes to that register in order.
  assign ex_ready_o = !(ex_valid_i && w_b_valid && (ex_waddr_i == w_b_addr));
  assign w_ex_acc   = ex_valid_i && ex_ready_o;

  // A write to x0 completes its handshake but never raises a write enable.
  assign w_a_we = w_ex_acc  && (ex_waddr_i != '0);
  assign w_b_we = w_b_valid && (w_b_addr   != '0);

  // FIFO storage. It needs no reset because the pointers and count qualify every entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= xif_waddr_i;
      r_fifo_data[r_wptr] <= xif_wdata_i;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered write ports. Address and data hold their last values while the port is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we_a    <= 1'b0;
      r_waddr_a <= '0;
      r_wdata_a <= '0;
      r_we_b    <= 1'b0;
      r_waddr_b <= '0;
      r_wdata_b <= '0;
    end else begin
      r_we_a <= w_a_we;
      r_we_b <= w_b_we;
      if (w_a_we) begin
        r_waddr_a <= ex_waddr_i;
        r_wdata_a <= ex_wdata_i;
      end
      if (w_b_we) begin
        r_waddr_b <= w_b_addr;
        r_wdata_b <= w_b_data;
      end
    end
  end

  assign we_a_o       = r_we_a;
  assign waddr_a_o    = r_waddr_a;
  assign wdata_a_o    = r_wdata_a;
  assign we_b_o       = r_we_b;
  assign waddr_b_o    = r_waddr_b;
  assign wdata_b_o    = r_wdata_b;
  assign fifo_level_o = r_count;

`ifdef CV32E40PX_RF_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] r_busy, w_set, w_clr;

  // A reservation sets its bit. A write that is decided this cycle clears its bit.
  // The clear lands on the same edge on which the write enable rises.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (rsv_valid_i && (rsv_addr_i != '0)) w_set[rsv_addr_i] = 1'b1;
    if (w_a_we) w_clr[ex_waddr_i] = 1'b1;
    if (w_b_we) w_clr[w_b_addr]   = 1'b1;
  end

  // The busy bitmap. When a set and a clear hit the same bit, the set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= (r_busy & ~w_clr) | w_set;
  end

  assign busy_o = r_busy;
`else
  logic w_unused_rsv;
  assign w_unused_rsv = rsv_valid_i ^ (^rsv_addr_i);
  assign busy_o       = '0;
`endif

endmodule

// File: tb/tb_cv32e40px_rf_wb_arbiter.sv
// Self-checking bench for cv32e40px_rf_wb_arbiter.
// Expected writes, with their expected cycle, go into per-port queues when stimulus is
// driven. They are popped and compared when the DUT raises a write enable.
module tb_cv32e40px_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, lsu_valid_i, xif_valid_i, rsv_valid_i;
  logic [5:0]  ex_waddr_i, lsu_waddr_i, xif_waddr_i, rsv_addr_i;
  logic [31:0] ex_wdata_i, lsu_wdata_i, xif_wdata_i;
  logic        ex_ready_o, xif_ready_o, we_a_o, we_b_o;
  logic [63:0] busy_o;
  logic [2:0]  fifo_level_o;
  logic [5:0]  waddr_a_o, waddr_b_o;
  logic [31:0] wdata_a_o, wdata_b_o;

  cv32e40px_rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .xif_valid_i(xif_valid_i), .xif_ready_o(xif_ready_o), .xif_waddr_i(xif_waddr_i), .xif_wdata_i(xif_wdata_i),
    .rsv_valid_i(rsv_valid_i), .rsv_addr_i(rsv_addr_i), .busy_o(busy_o), .fifo_level_o(fifo_level_o),
    .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
    .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Write monitor. It samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (we_a_o) begin
        if (qa.size() == 0) chk("a_unexpected_write", {58'd0, waddr_a_o}, 64'hffff);
        else begin
          exp_t e;
          e = qa.pop_front();
          chk("a_addr", waddr_a_o, e.addr);
          chk("a_data", wdata_a_o, e.data);
          chk("a_cycle", cyc, e.cyc);
        end
      end
      if (we_b_o) begin
        if (qb.size() == 0) chk("b_unexpected_write", {58'd0, waddr_b_o}, 64'hffff);
        else begin
          exp_t e;
          e = qb.pop_front();
          chk("b_addr", waddr_b_o, e.addr);
          chk("b_data", wdata_b_o, e.data);
          chk("b_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid_i = 0; lsu_valid_i = 0; xif_valid_i = 0; rsv_valid_i = 0;
  endtask

  task automatic push_a(input logic [5:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.addr = a; e.data = d; e.cyc = c;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [5:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.addr = a; e.data = d; e.cyc = c;
    qb.push_back(e);
  endtask

  // Watchdog. It stops a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst = 1;
    idle();
    ex_waddr_i = 0; ex_wdata_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
    xif_waddr_i = 0; xif_wdata_i = 0; rsv_addr_i = 0;
    step(); step();
    chk("rst_we_a", we_a_o, 0);
    chk("rst_we_b", we_b_o, 0);
    chk("rst_waddr_a", waddr_a_o, 0);
    chk("rst_wdata_b", wdata_b_o, 0);
    chk("rst_level", fifo_level_o, 0);
    chk("rst_xif_ready", xif_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    rst = 0;
    step();

    // EX only: waddr 5 is accepted in cycle N and written on port A in N+1.
    ex_valid_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'h0000A5A5;
    #1 chk("ex_ready_plain", ex_ready_o, 1);
    push_a(5, 32'h0000A5A5, cyc + 1);
    step();
    // EX to x0: the handshake completes but no write is issued.
    ex_waddr_i = 0; ex_wdata_i = 32'h12345678;
    #1 chk("ex_ready_x0", ex_ready_o, 1);
    step(); idle();
    step();
    chk("a_hold_addr", waddr_a_o, 5);

    // XIF fill while an LSU x0 load holds port B. Four pushes fit; the fifth is refused.
    for (int i = 0; i < 5; i++) begin
      lsu_valid_i = 1; lsu_waddr_i = 0; lsu_wdata_i = 32'hDEAD;
      xif_valid_i = 1; xif_waddr_i = 6'(10 + i); xif_wdata_i = 32'h100 + i;
      #1 chk("xif_ready_fill", xif_ready_o, (i < 4) ? 1 : 0);
      step();
    end
    idle();
    c = cyc;
    #1 chk("level_full", fifo_level_o, 4);
    chk("xif_ready_full_pop", xif_ready_o, 0);
    for (int i = 0; i < 4; i++) push_b(6'(10 + i), 32'h100 + i, c + 1 + i);
    repeat (6) step();
    chk("level_drained", fifo_level_o, 0);

    // Conflict: EX and LSU both target register 7.
    ex_valid_i = 1; ex_waddr_i = 7; ex_wdata_i = 32'hE7;
    lsu_valid_i = 1; lsu_waddr_i = 7; lsu_wdata_i = 32'h17;
    #1 chk("ex_ready_conflict", ex_ready_o, 0);
    push_b(7, 32'h17, cyc + 1);
    step();
    lsu_valid_i = 0;
    #1 chk("ex_ready_after_conflict", ex_ready_o, 1);
    push_a(7, 32'hE7, cyc + 1);
    step(); idle();
    step();

    // The LSU preempts the FIFO head. EX hits the held head address, so it does not stall.
    xif_valid_i = 1; xif_waddr_i = 20; xif_wdata_i = 32'h2020;
    step();
    xif_valid_i = 0;
    lsu_valid_i = 1; lsu_waddr_i = 21; lsu_wdata_i = 32'h2121;
    ex_valid_i = 1; ex_waddr_i = 20; ex_wdata_i = 32'hE20;
    #1 chk("ex_ready_no_conflict", ex_ready_o, 1);
    push_b(21, 32'h2121, cyc + 1);
    push_a(20, 32'hE20, cyc + 1);
    push_b(20, 32'h2020, cyc + 2);
    step(); idle();
    step(); step();

    // EX conflicts with the FIFO head being drained.
    xif_valid_i = 1; xif_waddr_i = 12; xif_wdata_i = 32'hC12;
    step();
    xif_valid_i = 0;
    ex_valid_i = 1; ex_waddr_i = 12; ex_wdata_i = 32'hE12;
    #1 chk("ex_ready_fifo_conflict", ex_ready_o, 0);
    push_b(12, 32'hC12, cyc + 1);
    step();
    #1 chk("ex_ready_fifo_clear", ex_ready_o, 1);
    push_a(12, 32'hE12, cyc + 1);
    step(); idle();
    step();

    // A push and a pop in the same cycle leave the level unchanged.
    xif_valid_i = 1; xif_waddr_i = 30; xif_wdata_i = 32'h30;
    step();
    c = cyc;
    xif_waddr_i = 31; xif_wdata_i = 32'h31;
    push_b(30, 32'h30, c + 1);
    push_b(31, 32'h31, c + 2);
    step(); xif_valid_i = 0;
    chk("level_push_pop", fifo_level_o, 1);
    step(); step();

    // Reset mid-drain at level 3. No write may follow once reset is released.
    for (int i = 0; i < 4; i++) begin
      lsu_valid_i = 1; lsu_waddr_i = 0;
      xif_valid_i = 1; xif_waddr_i = 6'(40 + i); xif_wdata_i = 32'h400 + i;
      step();
    end
    idle();
    step();
    chk("level_pre_reset", fifo_level_o, 3);
    rst = 1;
    #1;
    chk("mid_rst_we_a", we_a_o, 0);
    chk("mid_rst_we_b", we_b_o, 0);
    chk("mid_rst_level", fifo_level_o, 0);
    chk("mid_rst_xif_ready", xif_ready_o, 1);
    step();
    rst = 0;
    repeat (5) step();
    chk("post_rst_level", fifo_level_o, 0);

`ifdef CV32E40PX_RF_WB_SCOREBOARD_EN
    // Scoreboard: set, ignore x0, clear on write, set winning over clear.
    rsv_valid_i = 1; rsv_addr_i = 9;
    step();
    rsv_addr_i = 0;
    step();
    rsv_valid_i = 0;
    chk("sb_set9", busy_o[9], 1);
    chk("sb_x0", busy_o[0], 0);
    lsu_valid_i = 1; lsu_waddr_i = 9; lsu_wdata_i = 32'h99;
    push_b(9, 32'h99, cyc + 1);
    step();
    lsu_valid_i = 0;
    chk("sb_clear9", busy_o[9], 0);
    lsu_valid_i = 1; lsu_wdata_i = 32'h999;
    rsv_valid_i = 1; rsv_addr_i = 9;
    push_b(9, 32'h999, cyc + 1);
    step(); idle();
    chk("sb_set_wins", busy_o[9], 1);
    step();
`else
    rsv_valid_i = 1; rsv_addr_i = 9;
    step(); idle();
    chk("busy_tied_zero", busy_o, 0);
`endif

    repeat (4) step();
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
